// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default sizes for the direct-mapped data cache
package cache_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_INDEX_BITS    = 3;

  // Controller states: serve hits, refill a line, or push a store to memory.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL       = 2'd1,
    WRITE_THRU = 2'd2
  } cacheState_e;

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - valid/tag/data storage with one write port and combinational read
import cache_pkg::*;

module cache_array #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TAG_WIDTH  = 27,
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] index,
  input  logic                  wrEn,
  input  logic [TAG_WIDTH-1:0]  wrTag,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  rdValid,
  output logic [TAG_WIDTH-1:0]  rdTag,
  output logic [DATA_WIDTH-1:0] rdData
);

  localparam int NUM_SETS = 1 << INDEX_BITS;

  logic [NUM_SETS-1:0]   validBits;
  logic [TAG_WIDTH-1:0]  tagMem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] dataMem [NUM_SETS];

  // Valid bits are the only reset state; a write always marks the set valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validBits <= '0;
    end else if (wrEn) begin
      validBits[index] <= 1'b1;
    end
  end

  // Tag and data are plain storage; stale contents are masked by the valid bit.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      tagMem[index]  <= wrTag;
      dataMem[index] <= wrData;
    end
  end

  assign rdValid = validBits[index];
  assign rdTag   = tagMem[index];
  assign rdData  = dataMem[index];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache controller
import cache_pkg::*;

module data_cache #(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int INDEX_BITS    = DEFAULT_INDEX_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     re_i,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     stall_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_BITS - 2;

  cacheState_e state, nextState;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  lineValid;
  logic [TAG_WIDTH-1:0]  lineTag;
  logic [DATA_WIDTH-1:0] lineData;
  logic                  hit;
  logic                  arrWrEn;
  logic [DATA_WIDTH-1:0] arrWrData;

  assign index = addr_i[INDEX_BITS+1:2];
  assign tag   = addr_i[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign hit   = lineValid && (lineTag == tag);

  // Byte offset is masked rather than sliced so the whole address stays in use.
  assign mem_addr_o  = addr_i & ~ADDRESS_WIDTH'(3);
  assign mem_wdata_o = wdata_i;

  // Fills take memory data; write-through hits refresh the line with store data.
  assign arrWrData = (state == FILL) ? mem_rdata_i : wdata_i;

  cache_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .TAG_WIDTH (TAG_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .index  (index),
    .wrEn   (arrWrEn),
    .wrTag  (tag),
    .wrData (arrWrData),
    .rdValid(lineValid),
    .rdTag  (lineTag),
    .rdData (lineData)
  );

  // State register; reset abandons any outstanding memory request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and output decode; stores take priority over loads in IDLE.
  always_comb begin
    nextState = state;
    stall_o   = 1'b0;
    rdata_o   = '0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    arrWrEn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (we_i) begin
          stall_o   = 1'b1;
          nextState = WRITE_THRU;
        end else if (re_i) begin
          if (hit) begin
            rdata_o = lineData;
          end else begin
            stall_o   = 1'b1;
            nextState = FILL;
          end
        end
      end
      FILL: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          arrWrEn   = 1'b1;
          nextState = IDLE;
        end
      end
      WRITE_THRU: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        stall_o   = !mem_ack_i;
        if (mem_ack_i) begin
          arrWrEn   = hit;
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule
